adc_frame_spi_slave: RTL and testbench
======================================

# adc_frame_spi_slave

SPI responder through which the Raspberry Pi drains packed ADC frames from the sample FIFO. The ADS8681 capture block writes each frame as four 16-bit samples plus four 16-bit timestamps. This block decodes a command byte from the host and shifts out a status byte, then the 128-bit frame or the PPS tag timestamp. It pops the FIFO only after a complete frame transfer.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for SCK/CS/MOSI (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- SCK  in  1  host SPI clock, mode 0, asynchronous to clk
- CS  in  1  host chip select, active low
- MOSI  in  1  host data in
- MISO  out  1  data to host
- fifo_data  in  128  show-ahead FIFO head: {ADC_data_all[63:0], timestamp_all[63:0]}
- fifo_empty  in  1  FIFO has no frame
- fifo_rd_en  out  1  one-cycle pop strobe
- fifo_overflow  in  1  pulse: writer dropped a frame
- pps_tag_timestamp  in  16  timestamp latched at last PPS
- busy  out  1  transaction in progress (CS low, synchronized)

## Operation
- SCK, CS and MOSI pass through SYNC_STAGES flops. Rising and falling SCK edges are detected in the clk domain.
- MOSI is sampled on the SCK rising edge. MISO is updated on the SCK falling edge, MSB first.
- States:
  - IDLE: CS high. MISO=0.
  - CMD: shift 8 command bits.
  - RESP: shift the response register.
  - DONE: response exhausted, MISO=0 until CS high.
- IDLE→CMD when the synchronized CS falls.
- CMD→RESP after the 8th rising edge. The response register loads in the same cycle.
- RESP→DONE after the last response bit's rising edge.
- CS high in any state → IDLE on the next clk cycle.
- Commands:
  - 0x80 READ_FRAME: response is 136 bits: status byte followed by fifo_data[127:0].
  - 0x40 READ_PPS: response is 24 bits: status byte followed by pps_tag_timestamp.
  - Any other code: response is 8 bits: status byte only.
- Status byte: {frame_valid, overflow_flag, 6'b0}.
  - frame_valid = !fifo_empty at load time.
  - If frame_valid=0, the payload bits are 0.
- overflow_flag:
  - Set by fifo_overflow.
  - Cleared only when a READ_FRAME completes (reaches DONE).
  - Set wins over clear in the same cycle.
- FIFO pop:
  - fifo_rd_en pulses for exactly one cycle on the RESP→DONE transition.
  - Only for READ_FRAME, and only when frame_valid was 1.
  - CS rising before DONE (abort) causes no pop. The same frame is re-sent on the next read.
- Reset (async): state IDLE, MISO 0, fifo_rd_en 0, busy 0, overflow_flag 0, shift registers 0.

## Timing
- SCK frequency must be ≤ clk/8. SCK high and low times must each be ≥ 4 clk.
- MISO changes within SYNC_STAGES+1 clk cycles after an SCK falling edge.
- The first status bit is driven on the 8th SCK falling edge, before the 9th rising edge.
- Payload is frozen at load time. A FIFO write during RESP does not change the shifted data.
- The pop takes effect SYNC_STAGES+1 clk after the final SCK rising edge. The host must hold CS low ≥ 4 clk after the last SCK edge to avoid an abort.
- busy follows synchronized CS. It is 1 from CS falling until CS rising, both after SYNC_STAGES latency.

## Configuration
- FRAME_CRC_EN defined:
  - Appends a CRC-8 (poly 0x07, init 0x00), computed over the status byte and payload, after every response.
  - Lengths become 144/32/16 bits.
  - A READ_FRAME that aborts during the CRC byte causes no pop.
- FRAME_CRC_EN undefined: lengths are 136/24/8 and no CRC logic is present.

## Structure
- Shared package adc_link_pkg holds:
  - command codes (CMD_READ_FRAME, CMD_READ_PPS)
  - response lengths for both FRAME_CRC_EN settings
  - status bit positions
  - CRC polynomial
  - state enum
- One sub-module, spi_slave_sync: SYNC_STAGES synchronizers for SCK/CS/MOSI. Outputs sck_rise, sck_fall, cs_active, mosi_s.

## Test plan
- fifo_data=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, non-empty, READ_FRAME → MISO 8'h80 then that word; one fifo_rd_en pulse after the last bit.
- fifo_empty=1, READ_FRAME → status 8'h00, 128 zero bits, no fifo_rd_en.
- CS raised after 70 SCK cycles of a READ_FRAME → no pop; the next READ_FRAME returns the same word.
- fifo_overflow pulse, then READ_PPS with pps_tag_timestamp=16'hBEEF → 8'hC0 (or 8'h40 if empty) then BEEF; flag stays set until a READ_FRAME completes.
- Command 0x13 → status byte only, then zeros; assert rst mid-transfer → MISO=0, fifo_rd_en=0 immediately.
- FRAME_CRC_EN defined, READ_PPS with status 8'h00 and tag 16'h0000 → trailing CRC 8'h00; status 8'h80 and tag 0001 → bench-computed CRC-8 matches.

Source files
------------

// File: rtl/adc_link_pkg.sv
// Shared definitions for the ADC frame SPI link: command codes, response lengths, status layout, CRC.
// Response lengths for both FRAME_CRC_EN settings live here; the top picks one set.
package adc_link_pkg;

    localparam logic [7:0] CMD_READ_FRAME = 8'h80;
    localparam logic [7:0] CMD_READ_PPS   = 8'h40;

    localparam int LEN_FRAME     = 136;
    localparam int LEN_PPS       = 24;
    localparam int LEN_STAT      = 8;
    localparam int LEN_FRAME_CRC = 144;
    localparam int LEN_PPS_CRC   = 32;
    localparam int LEN_STAT_CRC  = 16;

    localparam int ST_FRAME_VALID = 7;
    localparam int ST_OVERFLOW    = 6;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP,
        ST_DONE
    } spi_state_e;

    // MSB-first CRC-8, init 0. Leading zero bits leave a zero CRC untouched, so
    // shorter messages can be right-aligned in the 136-bit vector.
    function automatic logic [7:0] crc8_136(input logic [135:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 135; i >= 0; i--) begin
            c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/adc_frame_spi_slave_if.sv
// Pin/FIFO bundle of the ADC frame SPI responder; slave = responder side, master = host/FIFO side.
interface adc_frame_spi_slave_if;
    logic         SCK;
    logic         CS;
    logic         MOSI;
    logic         MISO;
    logic [127:0] fifo_data;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         fifo_overflow;
    logic [15:0]  pps_tag_timestamp;
    logic         busy;

    modport slave (
        input  SCK, CS, MOSI, fifo_data, fifo_empty, fifo_overflow, pps_tag_timestamp,
        output MISO, fifo_rd_en, busy
    );

    modport master (
        output SCK, CS, MOSI, fifo_data, fifo_empty, fifo_overflow, pps_tag_timestamp,
        input  MISO, fifo_rd_en, busy
    );
endinterface

// File: rtl/spi_slave_sync.sv
// Brings SCK/CS/MOSI into the clk domain through SYNC_STAGES flops and detects SCK edges.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_active,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sck_prev_q;

    // CS resets high so a held-low CS during reset is only seen as a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q      <= '0;
            cs_q       <= '1;
            mosi_q     <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
            cs_q       <= {cs_q[SYNC_STAGES-2:0], cs_i};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise  =  sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall  = ~sck_q[SYNC_STAGES-1] &  sck_prev_q;
    assign cs_active = ~cs_q[SYNC_STAGES-1];
    assign mosi_s    =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/adc_frame_spi_slave.sv
// SPI mode-0 responder draining ADC frames / PPS tag from a show-ahead FIFO.
// FRAME_CRC_EN: when defined, appends a CRC-8 over status+payload to every response.
module adc_frame_spi_slave
    import adc_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_frame_spi_slave_if.slave  bus
);

`ifdef FRAME_CRC_EN
    localparam int LEN_F = LEN_FRAME_CRC;
    localparam int LEN_P = LEN_PPS_CRC;
    localparam int LEN_S = LEN_STAT_CRC;
`else
    localparam int LEN_F = LEN_FRAME;
    localparam int LEN_P = LEN_PPS;
    localparam int LEN_S = LEN_STAT;
`endif
    localparam int RESP_W = LEN_F;

    logic sck_rise, sck_fall, cs_active, mosi_s;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sck_i     (bus.SCK),
        .cs_i      (bus.CS),
        .mosi_i    (bus.MOSI),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_active (cs_active),
        .mosi_s    (mosi_s)
    );

    spi_state_e        state_q;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        bit_cnt_q;
    logic [7:0]        resp_len_q, resp_len_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              is_frame_q, frame_valid_q;
    logic              miso_q, rd_en_q;
    logic              ovf_q, ovf_d;
    logic [7:0]        status_d;
    logic [135:0]      body_d;
    logic              last_bit, ovf_clr;

    assign cmd_d = {cmd_q[6:0], mosi_s};

    // Response image is built right-aligned, then left-justified so the shifter always taps the MSB.
    always_comb begin
        status_d                 = 8'h00;
        status_d[ST_FRAME_VALID] = ~bus.fifo_empty;
        status_d[ST_OVERFLOW]    = ovf_q;
        body_d                   = {128'h0, status_d};
        resp_len_d               = 8'(LEN_S);
        case (cmd_d)
            CMD_READ_FRAME: begin
                body_d     = {status_d, (bus.fifo_empty ? 128'h0 : bus.fifo_data)};
                resp_len_d = 8'(LEN_F);
            end
            CMD_READ_PPS: begin
                body_d     = {112'h0, status_d, bus.pps_tag_timestamp};
                resp_len_d = 8'(LEN_P);
            end
            default: ;
        endcase
    end

`ifdef FRAME_CRC_EN
    logic [7:0] crc_d;
    assign crc_d  = crc8_136(body_d);
    assign resp_d = {body_d, crc_d} << (8'(RESP_W) - resp_len_d);
`else
    assign resp_d = body_d << (8'(RESP_W) - resp_len_d);
`endif

    assign last_bit = (bit_cnt_q == resp_len_q - 8'd1);
    // A completed READ_FRAME clears the flag whether or not a frame was present.
    assign ovf_clr  = cs_active & (state_q == ST_RESP) & sck_rise & last_bit & is_frame_q;
    assign ovf_d    = bus.fifo_overflow | (ovf_q & ~ovf_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            bit_cnt_q     <= '0;
            resp_len_q    <= '0;
            resp_q        <= '0;
            is_frame_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            miso_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            ovf_q   <= ovf_d;
            if (!cs_active) begin
                state_q   <= ST_IDLE;
                miso_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_CMD;
                        cmd_q     <= '0;
                        bit_cnt_q <= '0;
                        miso_q    <= 1'b0;
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_q <= cmd_d;
                            if (bit_cnt_q == 8'd7) begin
                                state_q       <= ST_RESP;
                                bit_cnt_q     <= '0;
                                resp_q        <= resp_d;
                                resp_len_q    <= resp_len_d;
                                is_frame_q    <= (cmd_d == CMD_READ_FRAME);
                                frame_valid_q <= ~bus.fifo_empty;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 8'd1;
                            end
                        end
                    end
                    ST_RESP: begin
                        if (sck_fall) begin
                            miso_q <= resp_q[RESP_W-1];
                            resp_q <= {resp_q[RESP_W-2:0], 1'b0};
                        end
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                            if (last_bit) begin
                                state_q <= ST_DONE;
                                miso_q  <= 1'b0;
                                rd_en_q <= is_frame_q & frame_valid_q;
                            end
                        end
                    end
                    ST_DONE: miso_q <= 1'b0;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.MISO       = miso_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.busy       = cs_active;

endmodule

// File: tb/tb_adc_frame_spi_slave.sv
// Directed bench for adc_frame_spi_slave: host-side SPI bit-banging with hand-computed responses.
module tb_adc_frame_spi_slave;

`ifdef FRAME_CRC_EN
    localparam int CW = 8;
`else
    localparam int CW = 0;
`endif
    localparam int LF   = 136 + CW;
    localparam int LP   = 24 + CW;
    localparam int LS   = 8 + CW;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    int   p;
    logic [127:0] W;
    logic [135:0] fw;
    logic [143:0] rx;

    adc_frame_spi_slave_if bus();

    adc_frame_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.fifo_rd_en === 1'b1) pops++;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start(input logic [7:0] cmd);
        bus.CS = 1'b0;
        nclk(HALF);
        for (int i = 7; i >= 0; i--) begin
            bus.MOSI = cmd[i];
            nclk(HALF);
            bus.SCK = 1'b1;
            nclk(HALF);
            bus.SCK = 1'b0;
        end
    endtask

    task automatic spi_read(input int n, output logic [143:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            nclk(HALF);
            r = {r[142:0], bus.MISO};
            bus.SCK = 1'b1;
            nclk(HALF);
            bus.SCK = 1'b0;
        end
    endtask

    task automatic spi_end();
        nclk(HALF);
        bus.CS = 1'b1;
        nclk(2 * HALF);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        W                     = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        fw                    = {8'h80, W};
        bus.SCK               = 1'b0;
        bus.CS                = 1'b1;
        bus.MOSI              = 1'b0;
        bus.fifo_data         = W;
        bus.fifo_empty        = 1'b0;
        bus.fifo_overflow     = 1'b0;
        bus.pps_tag_timestamp = 16'hBEEF;
        nclk(3);
        chk("rst_miso", bus.MISO, 1'b0);
        chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        nclk(4);

        // full frame read
        p = pops;
        spi_start(8'h80);
        chk("busy_active", bus.busy, 1'b1);
        spi_read(LF, rx);
        spi_end();
        chk("frame_data", rx >> CW, {8'h80, W});
        chk("frame_pop", pops - p, 1);
        chk("busy_idle", bus.busy, 1'b0);

        // empty FIFO: zero payload, no pop
        bus.fifo_empty = 1'b1;
        p = pops;
        spi_start(8'h80);
        spi_read(LF, rx);
        spi_end();
        chk("empty_data", rx >> CW, 144'h0);
        chk("empty_pop", pops - p, 0);
        bus.fifo_empty = 1'b0;

        // abort after 70 SCK cycles, then re-read the same frame
        p = pops;
        spi_start(8'h80);
        spi_read(62, rx);
        spi_end();
        chk("abort_head", rx[61:0], fw[135:74]);
        chk("abort_pop", pops - p, 0);
        p = pops;
        spi_start(8'h80);
        spi_read(LF, rx);
        spi_end();
        chk("retry_data", rx >> CW, {8'h80, W});
        chk("retry_pop", pops - p, 1);

        // overflow flag with a non-empty FIFO
        bus.fifo_overflow = 1'b1;
        nclk(1);
        bus.fifo_overflow = 1'b0;
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("pps_ovf", rx >> CW, 24'hC0BEEF);
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("pps_ovf_sticky", rx >> CW, 24'hC0BEEF);
        p = pops;
        spi_start(8'h80);
        spi_read(LF, rx);
        spi_end();
        chk("frame_ovf", rx >> CW, {8'hC0, W});
        chk("frame_ovf_pop", pops - p, 1);
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("pps_ovf_clr", rx >> CW, 24'h80BEEF);

        // overflow flag with an empty FIFO, cleared by an empty READ_FRAME
        bus.fifo_empty    = 1'b1;
        bus.fifo_overflow = 1'b1;
        nclk(1);
        bus.fifo_overflow = 1'b0;
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("pps_ovf_empty", rx >> CW, 24'h40BEEF);
        p = pops;
        spi_start(8'h80);
        spi_read(LF, rx);
        spi_end();
        chk("frame_ovf_empty", rx >> CW, {8'h40, 128'h0});
        chk("frame_ovf_empty_pop", pops - p, 0);
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("pps_empty_clr", rx >> CW, 24'h00BEEF);

`ifdef FRAME_CRC_EN
        bus.pps_tag_timestamp = 16'h0000;
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("crc_zero", rx[31:0], 32'h0000_0000);
        bus.fifo_empty        = 1'b0;
        bus.pps_tag_timestamp = 16'h0001;
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("crc_800001", rx[31:0], 32'h8000_010C);
        bus.pps_tag_timestamp = 16'hBEEF;
`endif

        // unknown command: status only, then zeros
        bus.fifo_empty = 1'b0;
        spi_start(8'h13);
        spi_read(LS + 16, rx);
        spi_end();
`ifdef FRAME_CRC_EN
        chk("cmd13", rx[31:0], 32'h8089_0000);
`else
        chk("cmd13", rx[23:0], 24'h80_0000);
`endif

        // reset while MISO is driving a 1 mid-frame
        p = pops;
        spi_start(8'h80);
        spi_read(15, rx);
        nclk(HALF);
        chk("pre_rst_miso", bus.MISO, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_miso", bus.MISO, 1'b0);
        chk("mid_rst_rd_en", bus.fifo_rd_en, 1'b0);
        bus.CS  = 1'b1;
        bus.SCK = 1'b0;
        nclk(4);
        rst = 1'b0;
        nclk(4);
        chk("mid_rst_pop", pops - p, 0);
        spi_start(8'h40);
        spi_read(LP, rx);
        spi_end();
        chk("post_rst_pps", rx >> CW, 24'h80BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
